// File: rtl/dma_fifo_param.sv
// Parametrised single-clock FIFO for the DMA read/write data paths: true full, fill level,
// advisory almost flags, sticky overflow/underflow and a show-ahead or registered read port.
module dma_fifo_param #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned AF_LEVEL  = 248,
  parameter int unsigned AE_LEVEL  = 8,
  parameter bit          SHOWAHEAD = 1'b1
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iClear,
  input  logic              FF_writerequest,
  input  logic [DATA_W-1:0] FF_data,
  input  logic              FF_readrequest,
  output logic [DATA_W-1:0] FF_q,
  output logic              FF_empty,
  output logic              FF_full,
  output logic              FF_almostfull,
  output logic              FF_almostempty,
  output logic [ADDR_W:0]   FF_usedw,
  output logic              FF_overflow,
  output logic              FF_underflow
);

  localparam logic [ADDR_W:0] DepthLvl = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AfLvl    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AeLvl    = (ADDR_W + 1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   usedw_q, usedw_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;

  // Status is derived only from the registered fill level.
  assign FF_usedw       = usedw_q;
  assign FF_empty       = (usedw_q == '0);
  assign FF_full        = (usedw_q == DepthLvl);
  assign FF_almostfull  = (usedw_q >= AfLvl);
  assign FF_almostempty = (usedw_q <= AeLvl);
  assign FF_overflow    = ovf_q;
  assign FF_underflow   = unf_q;

  assign wr_acc = FF_writerequest & ~FF_full;
  assign rd_acc = FF_readrequest & ~FF_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (iClear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      // Simultaneous accept leaves the level unchanged.
      if (wr_acc && !rd_acc) usedw_d = usedw_q + 1'b1;
      else if (rd_acc && !wr_acc) usedw_d = usedw_q - 1'b1;
      if (FF_writerequest && FF_full) ovf_d = 1'b1;
      if (FF_readrequest && FF_empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage has no reset; a flush only moves the pointers.
  always_ff @(posedge iClk) begin
    if (wr_acc && !iClear) mem[wr_ptr_q] <= FF_data;
  end

  if (SHOWAHEAD) begin : g_showahead
    assign FF_q = mem[rd_ptr_q];
  end else begin : g_registered
    logic [DATA_W-1:0] q_q;
    always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
        q_q <= '0;
      end else if (iClear) begin
        q_q <= '0;
      end else if (rd_acc) begin
        q_q <= mem[rd_ptr_q];
      end
    end
    assign FF_q = q_q;
  end

endmodule
